seq_detect_arbiter: RTL and testbench

SEQ_DETECT_ARBITER -- requirements
Module: seq_detect_arbiter

---
 rtl/seq_detect_arbiter.sv | 135 +++++++++++++
 tb/tb_seq_detect_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_arbiter.sv
// ---------------------------------------------------------------------------
// seq_detect_arbiter
//
// Several serial bit streams share one "1101" Mealy detector. A round-robin
// arbiter picks at most one channel per cycle. The shared detector advances
// that channel's saved context, and the context is written back. Detection
// overlaps, so 1101101 produces two hits.
//
// Ports
//   clk        : single clock, rising-edge active
//   reset      : asynchronous, active-high reset
//   bit_valid  : [NUM_CH] channel i offers a serial bit
//   bit_in     : [NUM_CH] serial data bits, qualified by bit_valid
//   bit_ready  : [NUM_CH] one-hot grant; a bit is consumed when valid&ready
//   ch_clear   : [NUM_CH] per-channel context clear (only with the macro)
//   hit_valid  : one-cycle pulse, the cycle after a pattern-completing bit
//   hit_ch     : channel of the last hit; holds between hits
//
// Optional feature: define SEQ_ARB_CLEAR_EN to add the ch_clear port.
// ---------------------------------------------------------------------------
module seq_detect_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] bit_valid,
  input  logic [NUM_CH-1:0] bit_in,
`ifdef SEQ_ARB_CLEAR_EN
  input  logic [NUM_CH-1:0] ch_clear,
`endif
  output logic [NUM_CH-1:0] bit_ready,
  output logic              hit_valid,
  output logic [CH_W-1:0]   hit_ch
);

  // One-hot detector states. IDLE means nothing useful has been seen yet.
  // A means "1" was seen, B means "11" was seen, and C means "110" was seen.
  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_A    = 4'b0010,
    S_B    = 4'b0100,
    S_C    = 4'b1000
  } ctx_t;

  logic [3:0]        ctx [NUM_CH];
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_any;
  logic [NUM_CH-1:0] grant;
  int                scan;
  logic [3:0]        cur_ctx;
  logic [3:0]        next_ctx;
  logic              cur_bit;
  logic              dec_hit;
  logic [NUM_CH-1:0] clear_vec;
  logic              hit_now;

`ifdef SEQ_ARB_CLEAR_EN
  assign clear_vec = ch_clear;
`else
  assign clear_vec = '0;
`endif

  // Round-robin search. The search starts at the priority pointer and
  // wraps around. The first channel found with a valid bit wins. While
  // reset is high, no channel is granted.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan      = 0;
    if (!reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        scan = int'(ptr) + k;
        if (scan >= NUM_CH) scan = scan - NUM_CH;
        if (!grant_any && bit_valid[scan]) begin
          grant_any = 1'b1;
          grant_idx = CH_W'(scan);
        end
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  assign bit_ready = grant;

  // Shared detector. This logic decodes the granted channel's saved
  // context. Any context that is not one-hot (corruption) falls back to
  // IDLE and produces no hit.
  always_comb begin
    cur_ctx  = ctx[grant_idx];
    cur_bit  = bit_in[grant_idx];
    next_ctx = S_IDLE;
    dec_hit  = 1'b0;
    case (cur_ctx)
      S_IDLE: next_ctx = cur_bit ? S_A : S_IDLE;
      S_A:    next_ctx = cur_bit ? S_B : S_IDLE;
      S_B:    next_ctx = cur_bit ? S_B : S_C;
      S_C: begin
        next_ctx = cur_bit ? S_A : S_IDLE;
        dec_hit  = cur_bit;
      end
      default: next_ctx = S_IDLE;
    endcase
  end

  // If a clear hits the granted channel in the same cycle, the clear wins.
  // The bit is still consumed, but it cannot produce a hit.
  assign hit_now = grant_any & dec_hit & ~clear_vec[grant_idx];

  // State register. It holds the per-channel contexts, the round-robin
  // pointer and the registered hit outputs. Only the granted channel's
  // context moves, unless a clear forces a channel to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) ctx[i] <= S_IDLE;
      ptr       <= '0;
      hit_valid <= 1'b0;
      hit_ch    <= '0;
    end else begin
      hit_valid <= hit_now;
      if (hit_now) hit_ch <= grant_idx;
      for (int i = 0; i < NUM_CH; i++) begin
        if (clear_vec[i])
          ctx[i] <= S_IDLE;
        else if (grant_any && (grant_idx == CH_W'(i)))
          ctx[i] <= next_ctx;
      end
      if (grant_any)
        ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_arbiter
//
// Self-checking bench for seq_detect_arbiter with four channels. The
// reference model keeps the last four consumed bits of each channel. A hit
// is reported when those four bits read 1101. Grants are predicted from a
// rotating priority pointer.
// ---------------------------------------------------------------------------
module tb_seq_detect_arbiter;

  localparam int NCH = 4;

  logic       clk;
  logic       reset;
  logic [3:0] bit_valid;
  logic [3:0] bit_in;
  logic [3:0] clear_drv;
  logic [3:0] bit_ready;
  logic       hit_valid;
  logic [1:0] hit_ch;

  int vectors;
  int miscompares;

  // Reference model state
  int         m_ptr;
  logic [3:0] m_hist [NCH];
  logic       m_hv;
  logic [1:0] m_hc;

  seq_detect_arbiter #(.NUM_CH(4), .CH_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
`ifdef SEQ_ARB_CLEAR_EN
    .ch_clear  (clear_drv),
`endif
    .bit_ready (bit_ready),
    .hit_valid (hit_valid),
    .hit_ch    (hit_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < NCH; i++) m_hist[i] = 4'b0000;
    m_hv = 1'b0;
    m_hc = 2'd0;
  endtask

  // Runs one clock cycle, starting and ending at a negedge. It returns the
  // observed and predicted values, and each caller compares them.
  task automatic step(input logic [3:0] v, input logic [3:0] b, input logic [3:0] clr,
                      output logic [3:0] rdy, output logic [3:0] erdy,
                      output logic hv, output logic ehv,
                      output logic [1:0] hc, output logic [1:0] ehc);
    int g;
    g = -1;
    bit_valid = v;
    bit_in    = b;
    clear_drv = clr;
    #1;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (m_ptr + k) % NCH;
      if (g < 0 && v[c]) g = c;
    end
    erdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    rdy  = bit_ready;
    @(posedge clk);
    m_hv = 1'b0;
    if (g >= 0) begin
      m_hist[g] = {m_hist[g][2:0], b[g]};
      if (m_hist[g] == 4'b1101 && !clr[g]) begin
        m_hv = 1'b1;
        m_hc = g[1:0];
      end
      m_ptr = (g + 1) % NCH;
    end
    for (int i = 0; i < NCH; i++) if (clr[i]) m_hist[i] = 4'b0000;
    #1;
    hv  = hit_valid;
    hc  = hit_ch;
    ehv = m_hv;
    ehc = m_hc;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bit_valid = 4'b1111;
    bit_in    = 4'b1111;
    clear_drv = 4'b0000;
    #1;
    vectors++;
    if (bit_ready !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_ready got=%b want=0000", bit_ready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (hit_valid !== 1'b0 || hit_ch !== 2'd0 || bit_ready !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_state got hv=%b hc=%0d rdy=%b want 0/0/0000", hit_valid, hit_ch, bit_ready);
    end
    @(negedge clk);
    reset     = 1'b0;
    bit_valid = 4'b0000;
    model_reset();
  endtask

  task automatic test_single_ch0();
    logic [3:0] pat, rdy, erdy;
    logic hv, ehv;
    logic [1:0] hc, ehc;
    int hits;
    pat = 4'b1101;
    hits = 0;
    for (int n = 3; n >= 0; n--) begin
      step(4'b0001, {3'b000, pat[n]}, 4'b0000, rdy, erdy, hv, ehv, hc, ehc);
      vectors++;
      if (rdy !== erdy) begin
        miscompares++;
        $display("[TB] FAIL ch0_ready got=%b want=%b", rdy, erdy);
      end
      vectors++;
      if (hv !== ehv || hc !== ehc) begin
        miscompares++;
        $display("[TB] FAIL ch0_hit got=%b/%0d want=%b/%0d", hv, hc, ehv, ehc);
      end
      if (hv === 1'b1) hits++;
    end
    vectors++;
    if (hits != 1) begin
      miscompares++;
      $display("[TB] FAIL ch0_hit_count got=%0d want=1", hits);
    end
  endtask

  task automatic test_overlap_ch2();
    logic [6:0] pat;
    logic [3:0] rdy, erdy;
    logic hv, ehv;
    logic [1:0] hc, ehc;
    int hits;
    pat = 7'b1101101;
    hits = 0;
    for (int n = 6; n >= 0; n--) begin
      step(4'b0100, {1'b0, pat[n], 2'b00}, 4'b0000, rdy, erdy, hv, ehv, hc, ehc);
      vectors++;
      if (rdy !== 4'b0100) begin
        miscompares++;
        $display("[TB] FAIL ch2_ready got=%b want=0100", rdy);
      end
      vectors++;
      if (hv !== ehv || hc !== ehc) begin
        miscompares++;
        $display("[TB] FAIL ch2_hit got=%b/%0d want=%b/%0d", hv, hc, ehv, ehc);
      end
      if (hv === 1'b1) hits++;
    end
    vectors++;
    if (hits != 2) begin
      miscompares++;
      $display("[TB] FAIL ch2_overlap_count got=%0d want=2", hits);
    end
  endtask

  task automatic test_all_channels();
    logic [3:0] pat, rdy, erdy;
    logic hv, ehv;
    logic [1:0] hc, ehc;
    pat = 4'b1101;
    test_reset();
    for (int c = 0; c < 16; c++) begin
      step(4'b1111, {4{pat[3 - c / 4]}}, 4'b0000, rdy, erdy, hv, ehv, hc, ehc);
      vectors++;
      if (rdy !== 4'(1 << (c % 4))) begin
        miscompares++;
        $display("[TB] FAIL rr_order cycle=%0d got=%b want=%b", c, rdy, 4'(1 << (c % 4)));
      end
      vectors++;
      if (hv !== (c >= 12) || (c >= 12 && hc !== 2'(c - 12))) begin
        miscompares++;
        $display("[TB] FAIL rr_hit cycle=%0d got=%b/%0d want=%b/%0d", c, hv, hc, (c >= 12), c - 12);
      end
    end
  endtask

  task automatic test_reset_mid_pattern();
    logic [6:0] pat;
    logic [3:0] rdy, erdy;
    logic hv, ehv;
    logic [1:0] hc, ehc;
    int hits;
    for (int n = 0; n < 3; n++)
      step(4'b0010, (n == 2) ? 4'b0000 : 4'b0010, 4'b0000, rdy, erdy, hv, ehv, hc, ehc);
    test_reset();
    pat = 5'b11101;
    hits = 0;
    for (int n = 4; n >= 0; n--) begin
      step(4'b0010, {2'b00, pat[n], 1'b0}, 4'b0000, rdy, erdy, hv, ehv, hc, ehc);
      vectors++;
      if (hv !== ehv || hc !== ehc) begin
        miscompares++;
        $display("[TB] FAIL rst_mid_hit got=%b/%0d want=%b/%0d", hv, hc, ehv, ehc);
      end
      if (hv === 1'b1) hits++;
      if (n == 4) begin
        vectors++;
        if (hv !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL rst_mid_stale got=%b want=0", hv);
        end
      end
    end
    vectors++;
    if (hits != 1) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_count got=%0d want=1", hits);
    end
  endtask

`ifdef SEQ_ARB_CLEAR_EN
  task automatic test_clear();
    logic [3:0] pat, rdy, erdy;
    logic hv, ehv;
    logic [1:0] hc, ehc;
    pat = 4'b1101;
    test_reset();
    for (int n = 3; n >= 0; n--) begin
      step(4'b1000, {pat[n], 3'b000}, (n == 0) ? 4'b1000 : 4'b0000, rdy, erdy, hv, ehv, hc, ehc);
      vectors++;
      if (rdy !== 4'b1000 || hv !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL clear_cycle got rdy=%b hv=%b want 1000/0", rdy, hv);
      end
    end
    // The context must be IDLE again: 1,1,0 followed by 1 completes only
    // after a full fresh 1101.
    for (int n = 3; n >= 0; n--) begin
      step(4'b1000, {pat[n], 3'b000}, 4'b0000, rdy, erdy, hv, ehv, hc, ehc);
      vectors++;
      if (hv !== (n == 0) || (n == 0 && hc !== 2'd3)) begin
        miscompares++;
        $display("[TB] FAIL clear_after got=%b/%0d want=%b/3", hv, hc, (n == 0));
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] v, b, clr, rdy, erdy;
    logic hv, ehv;
    logic [1:0] hc, ehc;
    int waitc [NCH];
    for (int i = 0; i < NCH; i++) waitc[i] = 0;
    v = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) v = 4'($urandom);
      b   = 4'($urandom);
      clr = 4'b0000;
`ifdef SEQ_ARB_CLEAR_EN
      if ($urandom_range(15) == 0) clr = 4'($urandom);
`endif
      step(v, b, clr, rdy, erdy, hv, ehv, hc, ehc);
      vectors++;
      if (rdy !== erdy || (rdy & ~v) !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL rand_ready cycle=%0d got=%b want=%b", c, rdy, erdy);
      end
      vectors++;
      if (hv !== ehv || hc !== ehc) begin
        miscompares++;
        $display("[TB] FAIL rand_hit cycle=%0d got=%b/%0d want=%b/%0d", c, hv, hc, ehv, ehc);
      end
      for (int i = 0; i < NCH; i++) begin
        if (v[i] && !rdy[i]) waitc[i]++;
        else waitc[i] = 0;
        if (waitc[i] >= NCH) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL rand_starve ch=%0d got_wait=%0d want<%0d", i, waitc[i], NCH);
          waitc[i] = 0;
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    bit_valid   = 4'b0000;
    bit_in      = 4'b0000;
    clear_drv   = 4'b0000;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_ch0();
    test_overlap_ch2();
    test_all_channels();
    test_reset_mid_pattern();
`ifdef SEQ_ARB_CLEAR_EN
    test_clear();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
